extrema_scheduler: RTL and testbench
====================================

Name: extrema_scheduler

Overview:
- Sequences the `check_extrema` block over every adjacent DoG layer pair of every octave.
- Drives the pair-select lines that steer the two BRAM read ports and pulses the checker's enable once per pair.
- Captures every extremum the checker reports, tagged with octave, layer and polarity, into a keypoint FIFO read by the descriptor stage through a valid/ready handshake.
- Sits between the DoG pyramid BRAM muxing and the keypoint consumer.

Parameters:
- DIMENSION, 64: image side length of the octave being checked; sets the x/y width `$clog2(DIMENSION)`.
- NUM_LAYERS, 4: DoG layers per octave; pairs per octave = NUM_LAYERS-1.
- NUM_OCTAVES, 3: octaves to sweep.
- FIFO_DEPTH, 16: keypoint FIFO entries; power of two.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to sweep all pairs.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last pair completes.
- pair_octave  out  $clog2(NUM_OCTAVES)  octave currently selected for the BRAM muxes.
- pair_layer  out  $clog2(NUM_LAYERS)  lower layer of the pair; the upper layer is pair_layer+1.
- chk_enable  out  1  one-cycle start pulse to `check_extrema`.
- chk_done  in  1  checker finished the current pair.
- chk_x, chk_y  in  $clog2(DIMENSION)  coordinate being reported.
- chk_first_is_extremum, chk_second_is_extremum  in  1  extremum in the lower / upper layer.
- chk_first_is_max, chk_second_is_max  in  1  polarity: 1 = maximum, 0 = minimum.
- kp_valid  out  1  FIFO head valid.
- kp_ready  in  1  consumer accepts the head.
- kp_x, kp_y  out  $clog2(DIMENSION)  keypoint coordinate.
- kp_octave, kp_layer  out  as pair_octave / pair_layer  keypoint DoG location.
- kp_is_max  out  1  keypoint polarity.
- drop_count  out  16  saturating count of keypoints lost to a full FIFO.
- timeout_flag  out  1  sticky pair-timeout indicator (optional feature).

Behaviour:
- Reset (rst_in low, asynchronous): FSM to IDLE; FIFO emptied.
  - All outputs 0: busy, done, chk_enable, pair_octave, pair_layer, kp_valid, drop_count, timeout_flag.
  - kp_* data outputs are 0.
- Reset mid-sweep aborts immediately. There is no resume.
- FSM states:
  - IDLE: start=1 → ARM; clear pair_octave/pair_layer to 0; busy=1. start while busy is ignored.
  - ARM: chk_enable=1 for exactly this cycle → GUARD.
  - GUARD: one cycle; chk_done is ignored, so a stale done from the previous pair is masked → RUN.
  - RUN: capture extrema every cycle. The first cycle with chk_done=1 → NEXT; extrema flagged in that same cycle are still captured.
  - NEXT: advance the pair.
    - If pair_layer < NUM_LAYERS-2: pair_layer+1.
    - Otherwise pair_layer=0 and pair_octave+1.
    - After the final pair (octave NUM_OCTAVES-1, layer NUM_LAYERS-2) → FIN; else → ARM.
  - FIN: done=1 for one cycle, busy=0 → IDLE. The FIFO is not drained first; kp_valid may remain high after done.
- Capture rules:
  - A chk_first_is_extremum push records {chk_x, chk_y, pair_octave, pair_layer, chk_first_is_max}.
  - A chk_second_is_extremum push uses layer pair_layer+1 and chk_second_is_max.
  - Both flags in one cycle give two pushes in that cycle, first-layer entry ordered ahead.
  - Each push succeeds only if a slot is free, counting a simultaneous pop: free slots = FIFO_DEPTH - count + (kp_valid & kp_ready).
  - With one free slot, the first-layer entry wins and the second is dropped.
  - Each dropped entry increments drop_count, saturating at 16'hFFFF.
  - No deduplication: a layer shared by two pairs may yield repeated keypoints.
- FIFO behaviour:
  - Show-ahead: the head is presented on kp_* while kp_valid=1.
  - The head pops on kp_valid & kp_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push into an empty FIFO gives kp_valid=1 on the next cycle.

Optional Feature:
- Macro: EXTREMA_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in GUARD/RUN.
  - If it reaches 4*DIMENSION*DIMENSION without chk_done, the FSM forces NEXT, sets timeout_flag=1 (sticky until reset), and the sweep continues.
- Undefined: RUN waits indefinitely for chk_done, and timeout_flag is tied to 0.

Test Plan:
- Reset, then pulse start with NUM_OCTAVES=3, NUM_LAYERS=4, and the checker model returning chk_done 10 cycles after each enable → exactly 9 chk_enable pulses, (octave,layer) sequence (0,0),(0,1),(0,2),(1,0)…(2,2), one done pulse, busy low afterwards.
- During pair (1,2) report first extremum at (3,4) max and second at (3,4) min in the same cycle, kp_ready=1 → two entries popped in order: {3,4,oct1,lay2,max} then {3,4,oct1,lay3,min}.
- Hold kp_ready=0 and report 20 single extrema with FIFO_DEPTH=16 → kp_valid=1, 16 entries retained in order, drop_count=4.
- Fill FIFO to 15, then report both flags in one cycle with kp_ready=0 → first-layer entry stored, drop_count+1. Repeat with kp_ready=1 → both stored.
- Assert chk_done high continuously from before ARM → GUARD masks it, so each pair still lasts at least 3 cycles and exactly 9 enables occur. Pulse start while busy → ignored.
- Drop rst_in low mid-sweep during pair (0,1) → all outputs 0 asynchronously. With EXTREMA_SCHED_TIMEOUT_EN defined and chk_done never asserted → timeout_flag=1 after 16384 cycles (DIMENSION=64), and the sweep advances.

Source files
------------

// File: rtl/extrema_scheduler_if.sv
// Keypoint stream from extrema_scheduler to the descriptor stage.
// Show-ahead valid/ready: the head entry is presented while kp_valid is high.
interface extrema_scheduler_if #(
  parameter int DIMENSION   = 64,
  parameter int NUM_LAYERS  = 4,
  parameter int NUM_OCTAVES = 3
);
  localparam int XY_W  = $clog2(DIMENSION);
  localparam int OCT_W = $clog2(NUM_OCTAVES);
  localparam int LAY_W = $clog2(NUM_LAYERS);

  logic             kp_valid;
  logic             kp_ready;
  logic [XY_W-1:0]  kp_x;
  logic [XY_W-1:0]  kp_y;
  logic [OCT_W-1:0] kp_octave;
  logic [LAY_W-1:0] kp_layer;
  logic             kp_is_max;

  modport master (
    output kp_valid, kp_x, kp_y, kp_octave, kp_layer, kp_is_max,
    input  kp_ready
  );

  modport slave (
    input  kp_valid, kp_x, kp_y, kp_octave, kp_layer, kp_is_max,
    output kp_ready
  );
endinterface

// File: rtl/extrema_scheduler.sv
// Sweeps check_extrema over every adjacent DoG layer pair and queues reported extrema.
// Optional pair timeout: define EXTREMA_SCHED_TIMEOUT_EN.
module extrema_scheduler #(
  parameter int DIMENSION   = 64,
  parameter int NUM_LAYERS  = 4,
  parameter int NUM_OCTAVES = 3,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_OCTAVES)-1:0] pair_octave,
  output logic [$clog2(NUM_LAYERS)-1:0]  pair_layer,
  output logic                           chk_enable,
  input  logic                           chk_done,
  input  logic [$clog2(DIMENSION)-1:0]   chk_x,
  input  logic [$clog2(DIMENSION)-1:0]   chk_y,
  input  logic                           chk_first_is_extremum,
  input  logic                           chk_second_is_extremum,
  input  logic                           chk_first_is_max,
  input  logic                           chk_second_is_max,
  extrema_scheduler_if.master            kp,
  output logic [15:0]                    drop_count,
  output logic                           timeout_flag
);
  localparam int XY_W  = $clog2(DIMENSION);
  localparam int OCT_W = $clog2(NUM_OCTAVES);
  localparam int LAY_W = $clog2(NUM_LAYERS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_GUARD, S_RUN, S_NEXT, S_FIN} state_t;

  typedef struct packed {
    logic [XY_W-1:0]  x;
    logic [XY_W-1:0]  y;
    logic [OCT_W-1:0] octave;
    logic [LAY_W-1:0] layer;
    logic             is_max;
  } kp_entry_t;

  state_t           state;
  kp_entry_t        mem [FIFO_DEPTH];
  kp_entry_t        head, entry_a, entry_b;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   free_slots;
  logic             pop, want_a, want_b, push_a, push_b, timeout_hit, last_pair;
  logic [1:0]       n_push, n_drop;
  logic [16:0]      drop_sum;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    pop        = (count != '0) && kp.kp_ready;
    want_a     = (state == S_RUN) && chk_first_is_extremum;
    want_b     = (state == S_RUN) && chk_second_is_extremum;
    free_slots = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, count} + (CNT_W+1)'(pop);
    // With a single free slot the lower-layer entry takes it.
    push_a     = want_a && (free_slots != '0);
    push_b     = want_b && (free_slots > (CNT_W+1)'(push_a));
    n_push     = {1'b0, push_a} + {1'b0, push_b};
    n_drop     = {1'b0, want_a & ~push_a} + {1'b0, want_b & ~push_b};
    drop_sum   = {1'b0, drop_count} + 17'(n_drop);
    entry_a    = '{x: chk_x, y: chk_y, octave: pair_octave, layer: pair_layer,
                   is_max: chk_first_is_max};
    entry_b    = '{x: chk_x, y: chk_y, octave: pair_octave, layer: pair_layer + LAY_W'(1),
                   is_max: chk_second_is_max};
    last_pair  = (pair_octave == OCT_W'(NUM_OCTAVES - 1)) &&
                 (pair_layer == LAY_W'(NUM_LAYERS - 2));
  end

  // NOTE: keypoint storage has no reset; only pointers and count are cleared, and the
  // outputs are gated by kp_valid so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= entry_a;
    if (push_b) mem[push_a ? wr_ptr + PTR_W'(1) : wr_ptr] <= entry_b;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(n_push);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count + CNT_W'(n_push) - CNT_W'(pop);
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign head         = mem[rd_ptr];
  assign kp.kp_valid  = (count != '0);
  assign kp.kp_x      = kp.kp_valid ? head.x      : '0;
  assign kp.kp_y      = kp.kp_valid ? head.y      : '0;
  assign kp.kp_octave = kp.kp_valid ? head.octave : '0;
  assign kp.kp_layer  = kp.kp_valid ? head.layer  : '0;
  assign kp.kp_is_max = kp.kp_valid ? head.is_max : 1'b0;

`ifdef EXTREMA_SCHED_TIMEOUT_EN
  localparam int TMO_LIMIT = 4 * DIMENSION * DIMENSION;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Fires on the cycle that completes TMO_LIMIT cycles spent in GUARD/RUN.
  assign timeout_hit = (state == S_RUN) && !chk_done && (tmo_cnt == TMO_W'(TMO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_GUARD || state == S_RUN) ? tmo_cnt + TMO_W'(1) : '0;
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      chk_enable  <= 1'b0;
      pair_octave <= '0;
      pair_layer  <= '0;
    end else begin
      chk_enable <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          state       <= S_ARM;
          busy        <= 1'b1;
          chk_enable  <= 1'b1;
          pair_octave <= '0;
          pair_layer  <= '0;
        end
        S_ARM:   state <= S_GUARD;
        // A done left over from the previous pair is ignored here.
        S_GUARD: state <= S_RUN;
        S_RUN:   if (chk_done || timeout_hit) state <= S_NEXT;
        S_NEXT: if (last_pair) begin
          state <= S_FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state      <= S_ARM;
          chk_enable <= 1'b1;
          if (pair_layer < LAY_W'(NUM_LAYERS - 2)) begin
            pair_layer <= pair_layer + LAY_W'(1);
          end else begin
            pair_layer  <= '0;
            pair_octave <= pair_octave + OCT_W'(1);
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_extrema_scheduler.sv
// Self-checking bench for extrema_scheduler: table-driven FIFO corner cases, directed
// sequencing/reset/timeout cases, and random sweeps against a queue-based reference model.
`timescale 1ns/1ps
module tb_extrema_scheduler;
  localparam int DIMENSION   = 64;
  localparam int NUM_LAYERS  = 4;
  localparam int NUM_OCTAVES = 3;
  localparam int FIFO_DEPTH  = 16;
  localparam int XY_W  = $clog2(DIMENSION);
  localparam int OCT_W = $clog2(NUM_OCTAVES);
  localparam int LAY_W = $clog2(NUM_LAYERS);
  localparam int PPO   = NUM_LAYERS - 1;
  localparam int NUM_PAIRS = NUM_OCTAVES * PPO;

  typedef enum int {DM_PULSE, DM_STUCK, DM_NEVER} done_mode_t;
  typedef struct { int x; int y; int oct; int lay; bit is_max; } kp_t;
  typedef struct { int pair_idx; int k; bit f; bit fm; bit s; bit sm; int x; int y; bit rdy; } rpt_t;
  typedef struct { int fill; bit rdy; bit f; bit fm; bit s; bit sm; int x; int y;
                   int exp_drops; int exp_drained; } row_t;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic start = 1'b0;
  logic busy, done, chk_enable, timeout_flag;
  logic [OCT_W-1:0] pair_octave;
  logic [LAY_W-1:0] pair_layer;
  logic chk_done = 1'b0;
  logic [XY_W-1:0] chk_x = '0, chk_y = '0;
  logic chk_first_is_extremum = 1'b0, chk_second_is_extremum = 1'b0;
  logic chk_first_is_max = 1'b0, chk_second_is_max = 1'b0;
  logic [15:0] drop_count;

  extrema_scheduler_if #(.DIMENSION(DIMENSION), .NUM_LAYERS(NUM_LAYERS),
                         .NUM_OCTAVES(NUM_OCTAVES)) kp_bus ();

  extrema_scheduler #(.DIMENSION(DIMENSION), .NUM_LAYERS(NUM_LAYERS),
                      .NUM_OCTAVES(NUM_OCTAVES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .busy(busy), .done(done),
    .pair_octave(pair_octave), .pair_layer(pair_layer), .chk_enable(chk_enable),
    .chk_done(chk_done), .chk_x(chk_x), .chk_y(chk_y),
    .chk_first_is_extremum(chk_first_is_extremum), .chk_second_is_extremum(chk_second_is_extremum),
    .chk_first_is_max(chk_first_is_max), .chk_second_is_max(chk_second_is_max),
    .kp(kp_bus), .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int n_compared = 0, n_mismatched = 0;
  int cyc = 0, cyc_since_en = -1, cur_pair = 0, cur_delay = 10, done_delay = 10;
  int n_enables = 0, n_dones = 0, n_pops = 0, last_en = -1, min_space = 1 << 30;
  int exp_drops = 0;
  bit rand_on = 0, rand_delay = 0, ready_rand = 0, ready_default = 0;
  done_mode_t done_mode = DM_PULSE;
  kp_t  exp_q[$];
  rpt_t script[$];
  row_t rows[9];

  task automatic check(input string name, input longint actual, input longint expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " chk_enable"}, chk_enable, 0);
    check({tag, " pair_octave"}, pair_octave, 0);
    check({tag, " pair_layer"}, pair_layer, 0);
    check({tag, " kp_valid"}, kp_bus.kp_valid, 0);
    check({tag, " drop_count"}, drop_count, 0);
    check({tag, " timeout_flag"}, timeout_flag, 0);
    check({tag, " kp data"}, {kp_bus.kp_x, kp_bus.kp_y, kp_bus.kp_octave, kp_bus.kp_layer,
                              kp_bus.kp_is_max}, 0);
  endtask

  // Reference model: one cycle of the keypoint queue with the free-slot rule.
  task automatic model_cycle(input bit f, input bit fm, input bit s, input bit sm,
                             input int x, input int y, input bit rdy);
    int  free;
    bit  pop_now;
    kp_t e;
    check("kp_valid", kp_bus.kp_valid, exp_q.size() > 0);
    check("drop_count", drop_count, exp_drops);
    if (exp_q.size() > 0)
      check("kp head {x,y,oct,lay,max}",
            {kp_bus.kp_x, kp_bus.kp_y, kp_bus.kp_octave, kp_bus.kp_layer, kp_bus.kp_is_max},
            {XY_W'(exp_q[0].x), XY_W'(exp_q[0].y), OCT_W'(exp_q[0].oct),
             LAY_W'(exp_q[0].lay), exp_q[0].is_max});
    pop_now = rdy && (exp_q.size() > 0);
    free = FIFO_DEPTH - exp_q.size() + int'(pop_now);
    if (pop_now) begin
      void'(exp_q.pop_front());
      n_pops++;
    end
    e.x = x; e.y = y; e.oct = cur_pair / PPO;
    if (f) begin
      e.lay = cur_pair % PPO; e.is_max = fm;
      if (free > 0) begin exp_q.push_back(e); free--; end
      else if (exp_drops < 65535) exp_drops++;
    end
    if (s) begin
      e.lay = cur_pair % PPO + 1; e.is_max = sm;
      if (free > 0) begin exp_q.push_back(e); free--; end
      else if (exp_drops < 65535) exp_drops++;
    end
  endtask

  // One clock: observe outputs, act as the checker and consumer, advance.
  task automatic step();
    bit f = 0, fm = 0, s = 0, sm = 0, rdy;
    int x = 0, y = 0;
    if (chk_enable) begin
      check("busy during pair", busy, 1);
      check("pair_octave at enable", pair_octave, n_enables / PPO);
      check("pair_layer at enable", pair_layer, n_enables % PPO);
      cur_pair = n_enables;
      n_enables++;
      if (last_en >= 0 && cyc - last_en < min_space) min_space = cyc - last_en;
      last_en = cyc;
      cyc_since_en = 0;
      cur_delay = rand_delay ? int'($urandom_range(12, 2)) : done_delay;
    end else if (cyc_since_en >= 0) begin
      cyc_since_en++;
    end
    if (done) n_dones++;
    rdy = ready_rand ? ($urandom_range(99) < 40) : ready_default;
    if (done_mode == DM_PULSE && cyc_since_en >= 2 && cyc_since_en <= cur_delay) begin
      foreach (script[i]) begin
        if (script[i].pair_idx == cur_pair && script[i].k == cyc_since_en) begin
          f = script[i].f; fm = script[i].fm; s = script[i].s; sm = script[i].sm;
          x = script[i].x; y = script[i].y; rdy = script[i].rdy;
        end
      end
      if (rand_on && $urandom_range(99) < 35) begin
        f = 1'($urandom_range(1)); fm = 1'($urandom_range(1));
        s = 1'($urandom_range(1)); sm = 1'($urandom_range(1));
        x = int'($urandom_range(DIMENSION - 1)); y = int'($urandom_range(DIMENSION - 1));
      end
    end
    chk_done = (done_mode == DM_STUCK) || (done_mode == DM_PULSE && cyc_since_en == cur_delay);
    chk_first_is_extremum = f; chk_first_is_max = fm;
    chk_second_is_extremum = s; chk_second_is_max = sm;
    chk_x = XY_W'(x); chk_y = XY_W'(y);
    kp_bus.kp_ready = rdy;
    model_cycle(f, fm, s, sm, x, y, rdy);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_in = 1'b0; start = 1'b0; chk_done = 1'b0;
    chk_first_is_extremum = 1'b0; chk_second_is_extremum = 1'b0;
    kp_bus.kp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b1;
    exp_q.delete(); script.delete();
    exp_drops = 0; cyc_since_en = -1; n_enables = 0; n_dones = 0; n_pops = 0;
    last_en = -1; min_space = 1 << 30; done_mode = DM_PULSE; done_delay = 10;
    rand_on = 0; rand_delay = 0; ready_rand = 0; ready_default = 0;
  endtask

  task automatic run_sweep(input bit poke_start);
    bit poked = 0;
    int n = 0;
    n_enables = 0; n_dones = 0; last_en = -1; min_space = 1 << 30;
    start = 1'b1; step(); start = 1'b0;
    while (n_dones == 0 && n < 2000) begin
      if (poke_start && !poked && n_enables == 3) begin start = 1'b1; poked = 1; end
      step(); start = 1'b0; n++;
    end
    check("sweep reached done within budget", n_dones, 1);
    step(); step();
    check("chk_enable pulses per sweep", n_enables, NUM_PAIRS);
    check("done pulses per sweep", n_dones, 1);
    check("busy after done", busy, 0);
  endtask

  task automatic drain();
    int n = 0;
    ready_rand = 0; ready_default = 1;
    while ((exp_q.size() > 0 || kp_bus.kp_valid) && n < 64) begin step(); n++; end
    check("fifo empty after drain", kp_bus.kp_valid, 0);
    ready_default = 0;
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        fill rdy f fm s sm x  y  drops drained
    rows[0] = '{0,  1, 1, 1, 1, 0, 3, 4, 0, 2};
    rows[1] = '{15, 0, 1, 1, 1, 0, 5, 6, 1, 16};
    rows[2] = '{15, 1, 1, 0, 1, 1, 7, 8, 0, 17};
    rows[3] = '{16, 0, 1, 1, 1, 1, 9, 9, 2, 16};
    rows[4] = '{16, 1, 1, 1, 1, 0, 10, 2, 1, 17};
    rows[5] = '{16, 0, 0, 0, 1, 1, 11, 3, 1, 16};
    rows[6] = '{15, 0, 0, 0, 1, 0, 12, 5, 0, 16};
    rows[7] = '{20, 0, 0, 0, 0, 0, 0, 0, 4, 16};
    rows[8] = '{20, 0, 1, 0, 0, 0, 13, 1, 5, 16};

    #3 check_all_zero("reset");
    do_reset();

    // Plain sweep, checker done 10 cycles after each enable.
    run_sweep(0);
    check("pair spacing with 10-cycle checker", min_space, 12);

    // FIFO capture corner cases, all reported during pair (1,2).
    foreach (rows[r]) begin
      do_reset();
      for (int i = 0; i < rows[r].fill; i++)
        script.push_back('{5, 2 + i, 1'b1, 1'(i % 2), 1'b0, 1'b0, i, i + 7, 1'b0});
      script.push_back('{5, 2 + rows[r].fill, rows[r].f, rows[r].fm, rows[r].s, rows[r].sm,
                         rows[r].x, rows[r].y, rows[r].rdy});
      done_delay = rows[r].fill + 2;
      run_sweep(0);
      check($sformatf("row %0d pair spacing", r), min_space, rows[r].fill + 4);
      check($sformatf("row %0d drop_count", r), drop_count, rows[r].exp_drops);
      check($sformatf("row %0d kp_valid after done", r), kp_bus.kp_valid, rows[r].exp_drained > 0);
      drain();
      check($sformatf("row %0d entries drained", r), n_pops, rows[r].exp_drained);
    end

    // chk_done stuck high from before start; start re-pulsed while busy.
    do_reset();
    done_mode = DM_STUCK;
    repeat (3) step();
    run_sweep(1);
    check("pair spacing with stuck chk_done", min_space, 4);

    // Random sweeps back to back against the reference model.
    do_reset();
    rand_on = 1; rand_delay = 1; ready_rand = 1;
    for (int sw = 0; sw < 4; sw++) run_sweep(0);
    drain();

    // Asynchronous reset during pair (0,1) with a full FIFO and drops recorded.
    do_reset();
    done_delay = 20;
    for (int i = 0; i < 18; i++) script.push_back('{0, 2 + i, 1'b1, 1'b1, 1'b0, 1'b0, i, i, 1'b0});
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 100 && n_enables < 2; n++) step();
    repeat (3) step();
    check("pre-reset busy", busy, 1);
    check("pre-reset pair_layer", pair_layer, 1);
    check("pre-reset kp_valid", kp_bus.kp_valid, 1);
    check("pre-reset drop_count", drop_count, 2);
    #2 rst_in = 1'b0;
    #1 check_all_zero("async reset mid-sweep");
    do_reset();
    repeat (5) step();
    check("no enable after reset abort", n_enables, 0);

`ifdef EXTREMA_SCHED_TIMEOUT_EN
    do_reset();
    done_mode = DM_NEVER;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 20000 && n_enables < 2; n++) begin
      if (n_enables == 1 && cyc_since_en == 16000) check("timeout_flag before limit", timeout_flag, 0);
      step();
    end
    check("sweep advanced after timeout", n_enables, 2);
    check("timeout_flag set", timeout_flag, 1);
    check("timeout pair spacing", min_space, 4 * DIMENSION * DIMENSION + 2);
    repeat (3) step();
    check("timeout_flag sticky", timeout_flag, 1);
`else
    do_reset();
    done_mode = DM_NEVER;
    start = 1'b1; step(); start = 1'b0;
    repeat (300) step();
    check("timeout_flag tied low", timeout_flag, 0);
    check("still busy waiting for chk_done", busy, 1);
    check("single enable while waiting", n_enables, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
